// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and entry type for the instruction fetch unit
// Holds default address/data widths, buffer depth and the pc+instr entry layout.
package fetch_pkg;

  localparam int DEF_AW    = 11;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 4;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_AW-1:0] pc;
    logic [DEF_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy count
// Ports: clk, reset (sync, active low); push_i/wdata_i write side; pop_i read side
// with rdata_o showing the head; flush_i empties the queue; full_o, empty_o, count_o status.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A full queue can still take a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assert property (@(posedge clk) disable iff (!reset) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch between PC register, imem and decode
// Ports: clk, reset (sync, active low); pc_in current PC, pc_next value loaded into the PC
// register; redirect/redirect_pc pipeline flush; imem_req_* read request (addr = pc_in);
// imem_rsp_* in-order read data; out_valid/out_instr/out_pc/out_ready decode handshake.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] pc_next,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          out_valid,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]    buf_count, tag_count;
  logic             buf_full, buf_empty, tag_full, tag_empty;
  logic [AW-1:0]    tag_pc;
  logic [AW+DW-1:0] buf_rdata;
  logic             credit_ok, accept, rsp, drop, buf_push, buf_pop;

  // Every outstanding request already owns a buffer slot, so responses never stall.
  assign credit_ok      = ({1'b0, inflight_q} + {1'b0, buf_count}) < (CW+1)'(DEPTH);
  assign imem_req_valid = reset & ~redirect & credit_ok;
  assign imem_req_addr  = pc_in;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rsp      = reset & imem_rsp_valid;
  // A response landing in the redirect cycle is from the old path too.
  assign drop     = rsp & (redirect | (drop_cnt_q != '0));
  assign buf_push = rsp & ~drop;

  assign out_valid = reset & ~buf_empty;
  assign buf_pop   = out_valid & out_ready;
  assign out_pc    = buf_rdata[AW+DW-1:DW];
  assign out_instr = buf_rdata[DW-1:0];

  always_comb begin
    pc_next = pc_in;
    if (!reset)        pc_next = '0;
    else if (redirect) pc_next = redirect_pc;
    else if (accept)   pc_next = pc_in + AW'(1);
  end

  always_comb begin
    inflight_d = inflight_q + CW'(accept) - CW'(rsp);
    drop_cnt_d = drop_cnt_q;
    // Everything still outstanding after this edge belongs to the abandoned path.
    if (redirect)  drop_cnt_d = inflight_q - CW'(rsp);
    else if (drop) drop_cnt_d = drop_cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Tags are never flushed: each one drains with its (possibly dropped) response.
  fetch_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_tag (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .wdata_i (pc_in),
    .pop_i   (rsp),
    .flush_i (1'b0),
    .rdata_o (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  fetch_fifo #(.WIDTH(AW+DW), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (buf_push),
    .wdata_i ({tag_pc, imem_rsp_data}),
    .pop_i   (buf_pop),
    .flush_i (redirect),
    .rdata_o (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assert property (@(posedge clk) disable iff (!reset) tag_count == inflight_q);
  assert property (@(posedge clk) disable iff (!reset) !(rsp && tag_empty));
  assert property (@(posedge clk) disable iff (!reset) !(accept && tag_full));
  assert property (@(posedge clk) disable iff (!reset) !(buf_push && buf_full));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer side of the PC register. Reads the current PC (npc) every cycle and issues in-order read requests to instruction memory.
- Pairs each returned instruction with its PC and presents both to decode over a valid/ready handshake.
- Drives the value to be loaded back into the PC register: pc+1, hold, or a redirect target.
- Absorbs memory latency and decode back-pressure in a small buffer; flushes on redirect.

Parameters:
AW, 11, PC/address width
DW, 32, instruction width
DEPTH, 4, buffer entries (power of 2, ≥2); also the max in-flight + buffered total

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
pc_in  in  AW  current PC from PC register output
redirect  in  1  branch/jump taken; flush pipeline
redirect_pc  in  AW  target PC when redirect=1
pc_next  out  AW  value to write into PC register this cycle
imem_req_valid  out  1  read request valid
imem_req_addr  out  AW  read address (= pc_in)
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  read data valid (in order, ≥1 cycle after accept)
imem_rsp_data  in  DW  read data
out_valid  out  1  instruction available to decode
out_instr  out  DW  instruction
out_pc  out  AW  PC of out_instr
out_ready  in  1  decode accepts

Behaviour:
- Reset (reset=0 at a clk edge): buffer empty, inflight=0, drop_cnt=0. While reset=0: out_valid=0, imem_req_valid=0, pc_next=0.
- credit_ok = (inflight + occupancy) < DEPTH.
- imem_req_valid = reset & ~redirect & credit_ok. imem_req_addr = pc_in.
- Accept = imem_req_valid & imem_req_ready. On accept, push pc_in into the tag FIFO and inflight+1.
- pc_next:
  - redirect=1 → redirect_pc
  - else accept → pc_in+1, modulo 2^AW (2047→0 for AW=11)
  - else → pc_in (hold)
- Response with drop_cnt>0: pop the tag and discard the data; drop_cnt−1, inflight−1.
- Response with drop_cnt=0: pop the tag, write {tag, data} to the buffer; inflight−1.
- Credit guarantees a response always has a buffer slot. Any write to a full buffer is an assertion failure.
- Output: out_valid = buffer non-empty; out_pc/out_instr = head entry. Head pops on out_valid & out_ready.
- Buffer latency: a response written at edge N is visible on out_* after edge N (zero bubble when the buffer was empty). Throughput is 1 instr/cycle with 1-cycle memory latency and out_ready=1.
- Redirect at edge:
  - Buffer is cleared (the same-cycle out handshake still counts as consumed).
  - drop_cnt ← inflight, minus 1 if a response arrives that same cycle and is dropped by the old rule.
  - The tag FIFO is not cleared; tags drain with their dropped responses.
  - No request is issued that cycle.
- Simultaneous push and pop on the buffer are legal; occupancy is unchanged.
- Simultaneous accept and response: inflight is unchanged.
- Reset mid-operation: all state is cleared at once. Memory responses arriving after reset are not guaranteed discarded; the memory model must also reset.

Decomposition:
- Package fetch_pkg holds:
  - AW/DW/DEPTH defaults
  - typedef fetch_entry_t {pc[AW-1:0], instr[DW-1:0]}
  - PTR_W = $clog2(DEPTH)
- One sub-module, fetch_fifo: synchronous FIFO, parameterised width/depth, with push, pop, flush, full, empty and count. Instantiated twice: the instruction buffer (fetch_entry_t) and the tag FIFO (AW wide, never flushed).
- Top level keeps inflight/drop_cnt counters and the pc_next mux.

Test Plan:
- Reset then stream:
  - Stimulus: reset=0 for 2 cycles, then 1; pc_in tracks pc_next; memory ready=1, 1-cycle latency, data=addr*4; out_ready=1.
  - Required: pc_next 0,1,2,3…; out_pc 0,1,2 with out_instr 0,4,8 on consecutive cycles, no bubbles.
- Back-pressure:
  - Stimulus: out_ready=0 for 10 cycles.
  - Required: after 4 requests imem_req_valid=0 and pc_next holds at 4; occupancy=4, no overflow. With out_ready=1, entries 0..3 drain in order and requests resume at pc 4.
- Redirect with in-flight:
  - Stimulus: 3-cycle memory latency, pc at 5; redirect=1, redirect_pc=0x100 for one cycle.
  - Required: responses for pcs 3,4 are discarded. Next out_pc=0x100 with instr=0x400; no stale instruction appears.
- Wrap:
  - Stimulus: pc_in=2047 accepted.
  - Required: pc_next=0; out_pc=2047 followed by 0.
- Memory stall:
  - Stimulus: imem_req_ready=0 for 5 cycles at pc 7.
  - Required: pc_next=7 throughout; imem_req_valid=1, addr=7 stable; resumes normally after.
- Reset mid-stream:
  - Stimulus: reset=0 asserted while 2 instrs buffered.
  - Required: next cycle out_valid=0, imem_req_valid=0, pc_next=0; restart fetches from 0.
